// File: rtl/dram_pack.sv
`default_nettype none
// ===========================================================================
// dram_pack : shared constants, FSM state type and beat-index helper
// Rev 1.0
// ===========================================================================
package dram_pack;

  localparam int CONFIGURED_DQS_BITS = 1;
  localparam int BURST_DEFAULT       = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_WAIT = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD_PRE  = 3'd4,
    ST_RD_DATA = 3'd5,
    ST_RD_POST = 3'd6
  } state_e;

  // Critical-word-first ordering: beat k lands in slot (col + k) mod burst.
  function automatic logic [2:0] beat_index(input logic [2:0] col,
                                            input logic [2:0] beat,
                                            input int         burst);
    int s;
    s = int'(col) + int'(beat);
    if (s >= burst) s = s - burst;
    return 3'(s);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dram_burst_mem.sv
`default_nettype none
// ===========================================================================
// dram_burst_mem : burst storage, per-beat synchronous write, async read
// Rev 1.0
// ===========================================================================
module dram_burst_mem #(
  parameter int ADDR_W = 4,
  parameter int BURST  = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        beat_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  // No reset: contents must survive RST.
  logic [31:0] mem_q [2**ADDR_W][BURST];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i][beat_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i][beat_i];

endmodule
`default_nettype wire

// File: rtl/dram_data_responder.sv
`default_nettype none
// ===========================================================================
// dram_data_responder : DRAM-style burst data responder (DQ/DQS timing)
// Rev 1.0
// ===========================================================================
module dram_data_responder
  import dram_pack::*;
#(
  parameter int BURST  = dram_pack::BURST_DEFAULT,
  parameter int WL     = 4,
  parameter int RL     = 6,
  parameter int ADDR_W = 4
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           wr_cmd,
  input  logic                           rd_cmd,
  input  logic [ADDR_W-1:0]              addr,
  input  logic [2:0]                     col,
  inout  wire  [31:0]                    DQ,
  inout  wire  [CONFIGURED_DQS_BITS-1:0] DQS_t,
  inout  wire  [CONFIGURED_DQS_BITS-1:0] DQS_c,
  input  logic                           DM_n,
  output logic                           busy,
  output logic                           cmd_err,
  output logic                           strobe_err
);

  state_e                         state_q, state_d;
  logic [ADDR_W-1:0]              addr_q, addr_d;
  logic [2:0]                     col_q, col_d;
  logic [2:0]                     beat_q, beat_d;
  logic [7:0]                     cnt_q, cnt_d;
  logic                           cmd_err_q, cmd_err_d;
  logic                           strobe_err_q, strobe_err_d;
  logic [CONFIGURED_DQS_BITS-1:0] dqs_prev_q;

  logic [2:0]  slot;
  logic [31:0] rd_data;
  logic        mem_we;
  logic        dq_oe, dqs_oe, dqs_val;

  assign slot   = beat_index(col_q, beat_q, BURST);
  assign mem_we = (state_q == ST_WR_DATA) && DM_n && !RST;

  dram_burst_mem #(
    .ADDR_W (ADDR_W),
    .BURST  (BURST)
  ) u_mem (
    .clk     (CLK),
    .we_i    (mem_we),
    .addr_i  (addr_q),
    .beat_i  (slot),
    .wdata_i (DQ),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    col_d        = col_q;
    beat_d       = beat_q;
    cnt_d        = cnt_q;
    cmd_err_d    = 1'b0;
    strobe_err_d = strobe_err_q;

    if (state_q != ST_IDLE && (wr_cmd || rd_cmd)) cmd_err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (wr_cmd && rd_cmd) begin
          cmd_err_d = 1'b1;
        end else if (wr_cmd) begin
          addr_d  = addr;
          col_d   = col;
          beat_d  = 3'd0;
          cnt_d   = 8'(WL - 2);
          state_d = ST_WR_WAIT;
        end else if (rd_cmd) begin
          addr_d  = addr;
          col_d   = col;
          beat_d  = 3'd0;
          cnt_d   = 8'(RL - 4);
          state_d = ST_RD_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (cnt_q == 8'd0) state_d = ST_WR_DATA;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ST_WR_DATA: begin
        // A beat whose strobe did not toggle is still stored, only flagged.
        if (DQS_t == dqs_prev_q) strobe_err_d = 1'b1;
        beat_d = beat_q + 3'd1;
        if (beat_q == 3'(BURST - 1)) state_d = ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = 8'd1;
          state_d = ST_RD_PRE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RD_PRE: begin
        if (cnt_q == 8'd0) begin
          beat_d  = 3'd0;
          state_d = ST_RD_DATA;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RD_DATA: begin
        beat_d = beat_q + 3'd1;
        if (beat_q == 3'(BURST - 1)) state_d = ST_RD_POST;
      end
      ST_RD_POST: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    dqs_prev_q <= DQS_t;
    if (RST) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      col_q        <= 3'd0;
      beat_q       <= 3'd0;
      cnt_q        <= 8'd0;
      cmd_err_q    <= 1'b0;
      strobe_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      col_q        <= col_d;
      beat_q       <= beat_d;
      cnt_q        <= cnt_d;
      cmd_err_q    <= cmd_err_d;
      strobe_err_q <= strobe_err_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign cmd_err    = cmd_err_q;
  assign strobe_err = strobe_err_q;

  // DQS_t is high on beat 0 and toggles; preamble/postamble hold it low.
  assign dq_oe   = (state_q == ST_RD_DATA);
  assign dqs_oe  = (state_q == ST_RD_PRE) || (state_q == ST_RD_DATA) || (state_q == ST_RD_POST);
  assign dqs_val = (state_q == ST_RD_DATA) ? ~beat_q[0] : 1'b0;

  assign DQ    = dq_oe  ? rd_data : 'z;
  assign DQS_t = dqs_oe ? {CONFIGURED_DQS_BITS{dqs_val}}  : 'z;
  assign DQS_c = dqs_oe ? {CONFIGURED_DQS_BITS{~dqs_val}} : 'z;

endmodule
`default_nettype wire

// File: tb/tb_dram_data_responder.sv
`default_nettype none
// ===========================================================================
// tb_dram_data_responder : randomized self-checking bench with memory model
// Rev 1.0
// ===========================================================================
module tb_dram_data_responder;

  localparam int BURST  = 8;
  localparam int WL     = 4;
  localparam int RL     = 6;
  localparam int ADDR_W = 4;
  localparam int NDQS   = dram_pack::CONFIGURED_DQS_BITS;

  logic              CLK = 1'b0;
  logic              RST, wr_cmd, rd_cmd, DM_n;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        col;
  wire  [31:0]       DQ;
  wire  [NDQS-1:0]   DQS_t, DQS_c;
  logic              busy, cmd_err, strobe_err;

  logic              tb_dq_oe, tb_dqs_oe, tb_dqs;
  logic [31:0]       tb_dq;

  // A released bus floats high through these pull-ups.
  assign DQ    = tb_dq_oe  ? tb_dq : 'z;
  assign DQS_t = tb_dqs_oe ? {NDQS{tb_dqs}}  : 'z;
  assign DQS_c = tb_dqs_oe ? {NDQS{~tb_dqs}} : 'z;
  for (genvar g = 0; g < 32; g++) begin : g_pu_dq
    pullup (DQ[g]);
  end
  for (genvar g = 0; g < NDQS; g++) begin : g_pu_dqs
    pullup (DQS_t[g]);
    pullup (DQS_c[g]);
  end

  dram_data_responder #(
    .BURST (BURST), .WL (WL), .RL (RL), .ADDR_W (ADDR_W)
  ) dut (
    .CLK (CLK), .RST (RST), .wr_cmd (wr_cmd), .rd_cmd (rd_cmd),
    .addr (addr), .col (col), .DQ (DQ), .DQS_t (DQS_t), .DQS_c (DQS_c),
    .DM_n (DM_n), .busy (busy), .cmd_err (cmd_err), .strobe_err (strobe_err)
  );

  always #5 CLK = ~CLK;

  int          total  = 0;
  int          passed = 0;
  logic [31:0] model_mem [2**ADDR_W][BURST];
  bit          model_vld [2**ADDR_W][BURST];
  bit          strobe_exp;
  logic [31:0] wbeats [BURST];

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [2:0] c,
                          input logic [7:0] mask, input int hold_beat, input int inj_beat);
    int err_at;
    int k;
    err_at = -100;
    @(posedge CLK); #1;
    wr_cmd = 1'b1; addr = a; col = c; tb_dqs_oe = 1'b1; tb_dqs = ~tb_dqs;
    for (int i = 1; i <= WL + BURST; i++) begin
      @(posedge CLK); #1;
      wr_cmd = 1'b0; rd_cmd = 1'b0; addr = ADDR_W'($urandom); col = 3'($urandom);
      k = i - WL;
      if (k != hold_beat) tb_dqs = ~tb_dqs;
      if (k >= 0 && k < BURST) begin
        tb_dq_oe = 1'b1; tb_dq = wbeats[k]; DM_n = mask[k];
        if (k == inj_beat) begin rd_cmd = 1'b1; err_at = i + 1; end
        if (mask[k]) begin
          model_mem[a][(c + k) % BURST] = wbeats[k];
          model_vld[a][(c + k) % BURST] = 1'b1;
        end
        if (k == hold_beat) strobe_exp = 1'b1;
      end else begin
        tb_dq_oe = 1'b0; DM_n = 1'b1;
      end
      @(negedge CLK);
      total++;
      if (busy !== (i < WL + BURST)) $display("FAIL wr_busy cyc %0d: got %b want %b", i, busy, (i < WL + BURST));
      else passed++;
      total++;
      if (cmd_err !== (i == err_at)) $display("FAIL wr_cmd_err cyc %0d: got %b want %b", i, cmd_err, (i == err_at));
      else passed++;
    end
    tb_dqs_oe = 1'b0;
    total++;
    if (strobe_err !== strobe_exp) $display("FAIL wr_strobe_err: got %b want %b", strobe_err, strobe_exp);
    else passed++;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [2:0] c, input int rst_beat);
    logic [31:0] exp_dq;
    logic        exp_t, exp_c, exp_busy;
    bit          chk_dq;
    int          k, idx;
    @(posedge CLK); #1;
    rd_cmd = 1'b1; addr = a; col = c;
    for (int i = 1; i <= RL + BURST + 1; i++) begin
      @(posedge CLK); #1;
      rd_cmd = 1'b0; addr = ADDR_W'($urandom); col = 3'($urandom);
      RST = (rst_beat >= 0 && i - RL == rst_beat);
      if (RST) strobe_exp = 1'b0;
      @(negedge CLK);
      exp_busy = 1'b1; exp_dq = '1; chk_dq = 1'b1; exp_t = 1'b1; exp_c = 1'b1;
      if (rst_beat >= 0 && i > RL + rst_beat) begin
        exp_busy = 1'b0;
      end else if (i <= RL - 3) begin
        exp_busy = 1'b1;
      end else if (i < RL) begin
        exp_t = 1'b0;
      end else if (i < RL + BURST) begin
        k = i - RL; idx = (c + k) % BURST;
        exp_t = (k % 2 == 0); exp_c = ~exp_t;
        chk_dq = model_vld[a][idx]; exp_dq = model_mem[a][idx];
      end else if (i == RL + BURST) begin
        exp_t = 1'b0;
      end else begin
        exp_busy = 1'b0;
      end
      total++;
      if (busy !== exp_busy) $display("FAIL rd_busy cyc %0d: got %b want %b", i, busy, exp_busy);
      else passed++;
      if (chk_dq) begin
        total++;
        if (DQ !== exp_dq) $display("FAIL rd_dq cyc %0d: got %h want %h", i, DQ, exp_dq);
        else passed++;
      end
      total++;
      if (DQS_t !== {NDQS{exp_t}} || DQS_c !== {NDQS{exp_c}})
        $display("FAIL rd_dqs cyc %0d: got t=%b c=%b want t=%b c=%b", i, DQS_t, DQS_c, exp_t, exp_c);
      else passed++;
    end
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    total++;
    if (busy !== 1'b0 || cmd_err !== 1'b0 || strobe_err !== 1'b0)
      $display("FAIL reset_flags: got busy=%b cmd_err=%b strobe_err=%b want 0 0 0", busy, cmd_err, strobe_err);
    else passed++;
    total++;
    if (DQ !== 32'hFFFF_FFFF || DQS_t !== {NDQS{1'b1}})
      $display("FAIL reset_bus: got DQ=%h DQS_t=%b want released", DQ, DQS_t);
    else passed++;
    @(posedge CLK); #1; RST = 1'b0;
  endtask

  task automatic test_basic_write_read();
    for (int k = 0; k < BURST; k++) wbeats[k] = 32'h1000 + k;
    do_write(4'd3, 3'd0, 8'hFF, -100, -100);
    do_read(4'd3, 3'd0, -1);
  endtask

  task automatic test_wrap_read();
    do_read(4'd3, 3'd5, -1);
  endtask

  task automatic test_mask();
    for (int k = 0; k < BURST; k++) wbeats[k] = 32'hFFFF_FFFF;
    do_write(4'd3, 3'd0, 8'b1011_1011, -100, -100);
    do_read(4'd3, 3'd0, -1);
  endtask

  task automatic test_cmd_err();
    for (int k = 0; k < BURST; k++) wbeats[k] = 32'hA5A5_0000 + k;
    do_write(4'd7, 3'd2, 8'hFF, -100, 2);
    @(posedge CLK); #1; wr_cmd = 1'b1; rd_cmd = 1'b1;
    @(posedge CLK); #1; wr_cmd = 1'b0; rd_cmd = 1'b0;
    @(negedge CLK);
    total++;
    if (cmd_err !== 1'b1 || busy !== 1'b0) $display("FAIL both_cmd: got cmd_err=%b busy=%b want 1 0", cmd_err, busy);
    else passed++;
    @(posedge CLK); @(negedge CLK);
    total++;
    if (cmd_err !== 1'b0 || busy !== 1'b0) $display("FAIL both_cmd_after: got cmd_err=%b busy=%b want 0 0", cmd_err, busy);
    else passed++;
    do_read(4'd7, 3'd0, -1);
  endtask

  task automatic test_strobe_err();
    for (int k = 0; k < BURST; k++) wbeats[k] = $urandom;
    do_write(4'd9, 3'd1, 8'hFF, 4, -100);
    for (int k = 0; k < BURST; k++) wbeats[k] = $urandom;
    do_write(4'd10, 3'd0, 8'hFF, -100, -100);
    @(posedge CLK); #1; RST = 1'b1;
    @(posedge CLK); #1; RST = 1'b0; strobe_exp = 1'b0;
    @(negedge CLK);
    total++;
    if (strobe_err !== 1'b0) $display("FAIL strobe_clear: got %b want 0", strobe_err);
    else passed++;
  endtask

  task automatic test_reset_mid_read();
    do_read(4'd3, 3'd0, 3);
    do_read(4'd3, 3'd0, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        for (int k = 0; k < BURST; k++) wbeats[k] = $urandom;
        do_write(ADDR_W'($urandom), 3'($urandom), 8'($urandom | $urandom), -100, -100);
      end else begin
        do_read(ADDR_W'($urandom_range(0, 3) + 3), 3'($urandom), -1);
      end
    end
  endtask

  initial begin
    RST = 1'b1; wr_cmd = 1'b0; rd_cmd = 1'b0; addr = '0; col = 3'd0; DM_n = 1'b1;
    tb_dq_oe = 1'b0; tb_dq = '0; tb_dqs_oe = 1'b0; tb_dqs = 1'b0; strobe_exp = 1'b0;
    for (int a = 0; a < 2**ADDR_W; a++)
      for (int b = 0; b < BURST; b++) model_vld[a][b] = 1'b0;
    test_reset();
    test_basic_write_read();
    test_wrap_read();
    test_mask();
    test_cmd_err();
    test_strobe_err();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/dram_data_responder.md
DRAM_DATA_RESPONDER -- requirements
Module: dram_data_responder

Interface
REQ-001 SHALL have parameter BURST, default 8, beats per burst.
REQ-002 SHALL have parameter WL, default 4, cycles from wr_cmd to first write beat.
REQ-003 SHALL have parameter RL, default 6, cycles from rd_cmd to first read beat.
REQ-004 SHALL have parameter ADDR_W, default 4, burst-address width; storage is 2**ADDR_W bursts.
REQ-005 SHALL have port CLK, input, 1, the single clock; one DQ beat per cycle.
REQ-006 SHALL have port RST, input, 1, synchronous active-high reset, sampled on rising CLK.
REQ-007 SHALL have port wr_cmd, input, 1, write command strobe (one cycle).
REQ-008 SHALL have port rd_cmd, input, 1, read command strobe (one cycle).
REQ-009 SHALL have port addr, input, ADDR_W, burst address, sampled with the command.
REQ-010 SHALL have port col, input, 3, starting beat (critical-word-first), sampled with the command.
REQ-011 SHALL have port DQ, inout, 32, data bus.
REQ-012 SHALL have port DQS_t / DQS_c, inout, CONFIGURED_DQS_BITS each, strobe pair.
REQ-013 SHALL have port DM_n, input, 1, write beat mask, low = masked.
REQ-014 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-015 SHALL have port cmd_err, output, 1, one-cycle pulse when a command is rejected.
REQ-016 SHALL have port strobe_err, output, 1, sticky flag for a missing DQS toggle during a write beat.

Function
REQ-017 SHALL have FSM states IDLE, WR_WAIT, WR_DATA, RD_WAIT, RD_PRE, RD_DATA, RD_POST.
REQ-018 In IDLE, wr_cmd SHALL latch addr/col and go to WR_WAIT; rd_cmd SHALL latch addr/col and go to RD_WAIT.
REQ-019 wr_cmd and rd_cmd both high in IDLE SHALL be rejected: cmd_err pulses and the state stays IDLE.
REQ-020 Any command outside IDLE SHALL be rejected with cmd_err and SHALL NOT disturb the operation in progress.
REQ-021 WR_WAIT SHALL last WL-1 cycles, so that beat 0 is sampled exactly WL cycles after the wr_cmd cycle.
REQ-022 WR_DATA SHALL sample DQ on BURST consecutive cycles; beat k SHALL be written to mem[addr][(col+k) mod BURST] only when DM_n=1.
REQ-023 In WR_DATA, if DQS_t equals its previous-cycle sample on any beat, strobe_err SHALL set; the beat is still captured.
REQ-024 After the last write beat, the FSM SHALL return to IDLE on the next cycle.
REQ-025 RD_WAIT SHALL last RL-3 cycles, followed by RD_PRE for 2 cycles with DQS_t=0 / DQS_c=1 driven and DQ at Z.
REQ-026 RD_DATA SHALL drive beat k = mem[addr][(col+k) mod BURST] on DQ for BURST cycles, with beat 0 exactly RL cycles after rd_cmd.
REQ-027 In RD_DATA, DQS_t SHALL be 1 on beat 0 and toggle every beat; DQS_c SHALL always equal ~DQS_t.
REQ-028 RD_POST SHALL drive DQS_t=0 for 1 cycle with DQ at Z, then return to IDLE.
REQ-029 DQ SHALL be driven only in RD_DATA, and DQS only in RD_PRE, RD_DATA and RD_POST; both SHALL be Z otherwise.
REQ-030 The beat counter SHALL be 3 bits; (col+k) SHALL wrap modulo BURST.
REQ-031 A read SHALL return data written by a write that completed one or more cycles earlier.

Reset
REQ-032 On RST=1: state SHALL be IDLE, busy=0, cmd_err=0, strobe_err=0, and DQ/DQS SHALL be Z.
REQ-033 RST mid-burst SHALL abort the operation on the next edge and release the bus; beats already written remain in storage.
REQ-034 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-035 CONFIGURED_DQS_BITS, the BURST default and the FSM state enum typedef SHALL live in dram_pack.
REQ-036 Storage SHALL be one sub-module, dram_burst_mem: a 2**ADDR_W x BURST x 32 array with per-beat write enable and a combinational read port.

Verification
REQ-037 Write addr=3 col=0 with beats 0x1000+k at WL=4, DM_n=1 throughout, then read addr=3 col=0 -> DQ returns 0x1000..0x1007 starting 6 cycles after rd_cmd.
REQ-038 Read addr=3 col=5 -> returned beat order is 0x1005, 0x1006, 0x1007, 0x1000, ..., 0x1004.
REQ-039 Rewrite addr=3 with 0xFFFF_FFFF and DM_n=0 on beats 2 and 6 -> readback shows 0x1002 and 0x1006 unchanged and all other beats 0xFFFFFFFF.
REQ-040 Issue rd_cmd during WR_DATA, and wr_cmd and rd_cmd together in IDLE -> cmd_err pulses once each, and the in-flight write completes intact.
REQ-041 Hold DQS_t constant on write beat 4 -> strobe_err=1 and stays 1 until RST.
REQ-042 Assert RST on read beat 3 -> DQ/DQS are Z and busy=0 on the next cycle; a following read returns correct data.
